// File: rtl/lsnn_scheduler.sv
// Time-multiplexed adaptive (LSNN-style) neuron updater: N_NEURONS virtual neurons share one
// four-stage datapath. Define LSNN_REFRACTORY_EN to add a 2-bit refractory counter per neuron.
module lsnn_scheduler #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned ALPHA     = 8,
    parameter int unsigned B0        = 8,
    localparam int unsigned IdxW     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IdxW-1:0] in_idx,
    input  logic [7:0]      in_current,
    output logic            spike_valid,
    output logic [IdxW-1:0] spike_idx,
    output logic            spike,
    output logic [7:0]      threshold_out,
    output logic            busy
);

    localparam logic [7:0] AlphaV = 8'(ALPHA);
    localparam logic [7:0] B0V    = 8'(B0);

    typedef enum logic [1:0] {StIdle, StLoad, StUpdate, StWrite} state_e;

    state_e fsm_q, fsm_d;

    logic load_en, upd_en, wr_en, accept, idx_ok;

    // Per-neuron storage
    logic [7:0] st_mem [N_NEURONS];
    logic [7:0] ad_mem [N_NEURONS];

    // Transaction pipeline registers
    logic [IdxW-1:0] idx_q;
    logic [7:0]      cur_q;
    logic [7:0]      st_q, ad_q, thr_q;
    logic [7:0]      new_st_q, new_ad_q;
    logic            new_spike_q;

    logic            spike_valid_q, spike_q;
    logic [IdxW-1:0] spike_idx_q;
    logic [7:0]      thr_out_q;

    // Combinational load / update results
    logic [7:0] ld_st, ld_ad, ld_thr;
    logic [8:0] thr9;
    logic [8:0] sum9, grow9;
    logic [7:0] upd_st, upd_ad;
    logic       fire;

`ifdef LSNN_REFRACTORY_EN
    logic [1:0] rf_mem [N_NEURONS];
    logic [1:0] rf_q, new_rf_q, ld_rf, upd_rf;
`endif

    assign accept = in_valid && in_ready;
    assign idx_ok = (32'(idx_q) < N_NEURONS);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM: next state
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            StIdle:   if (accept) fsm_d = StLoad;
            StLoad:   fsm_d = StUpdate;
            StUpdate: fsm_d = StWrite;
            StWrite:  fsm_d = StIdle;
            default:  fsm_d = StIdle;
        endcase
    end

    // FSM: outputs and stage enables; in_ready is held low while reset is asserted
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        load_en  = 1'b0;
        upd_en   = 1'b0;
        wr_en    = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                busy     = 1'b0;
                in_ready = !rst_n;
            end
            StLoad:   load_en = 1'b1;
            StUpdate: upd_en  = 1'b1;
            StWrite:  wr_en   = 1'b1;
            default:  busy    = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // LOAD stage: fetch neuron storage, form saturated threshold
    // ------------------------------------------------------------------
    always_comb begin
        ld_st = '0;
        ld_ad = '0;
`ifdef LSNN_REFRACTORY_EN
        ld_rf = '0;
`endif
        if (idx_ok) begin
            ld_st = st_mem[idx_q];
            ld_ad = ad_mem[idx_q];
`ifdef LSNN_REFRACTORY_EN
            ld_rf = rf_mem[idx_q];
`endif
        end
        thr9 = 9'(ld_ad) + 9'(B0V);
        if (!idx_ok) begin
            ld_thr = '0;
        end else if (thr9[8]) begin
            ld_thr = 8'hFF;
        end else begin
            ld_thr = thr9[7:0];
        end
    end

    // ------------------------------------------------------------------
    // UPDATE stage: leaky integrate, fire, adapt
    // ------------------------------------------------------------------
    always_comb begin
        sum9   = 9'(cur_q) + 9'(st_q >> 1);
        upd_st = sum9[8] ? 8'hFF : sum9[7:0];
        // Out-of-range requests never fire, even though their threshold reads as zero
        fire   = idx_ok && (upd_st >= thr_q);
`ifdef LSNN_REFRACTORY_EN
        upd_rf = rf_q;
        if (rf_q != 2'd0) begin
            fire   = 1'b0;
            upd_rf = rf_q - 2'd1;
            upd_st = '0;
        end else if (fire) begin
            upd_rf = 2'd2;
            upd_st = '0;
        end
`endif
        grow9 = 9'(ad_q) + 9'(ad_q >> 2);
        if (fire) begin
            upd_ad = grow9[8] ? 8'hFF : grow9[7:0];
        end else begin
            upd_ad = (ad_q >> 1) + (ad_q >> 2);
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers, storage and reported result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                st_mem[i] <= '0;
                ad_mem[i] <= AlphaV;
`ifdef LSNN_REFRACTORY_EN
                rf_mem[i] <= '0;
`endif
            end
            idx_q         <= '0;
            cur_q         <= '0;
            st_q          <= '0;
            ad_q          <= '0;
            thr_q         <= '0;
            new_st_q      <= '0;
            new_ad_q      <= '0;
            new_spike_q   <= 1'b0;
`ifdef LSNN_REFRACTORY_EN
            rf_q          <= '0;
            new_rf_q      <= '0;
`endif
            spike_valid_q <= 1'b0;
            spike_q       <= 1'b0;
            spike_idx_q   <= '0;
            thr_out_q     <= '0;
        end else begin
            spike_valid_q <= 1'b0;
            if (accept) begin
                idx_q <= in_idx;
                cur_q <= in_current;
            end
            if (load_en) begin
                st_q  <= ld_st;
                ad_q  <= ld_ad;
                thr_q <= ld_thr;
`ifdef LSNN_REFRACTORY_EN
                rf_q  <= ld_rf;
`endif
            end
            if (upd_en) begin
                new_st_q    <= upd_st;
                new_ad_q    <= upd_ad;
                new_spike_q <= fire;
`ifdef LSNN_REFRACTORY_EN
                new_rf_q    <= upd_rf;
`endif
            end
            if (wr_en) begin
                if (idx_ok) begin
                    st_mem[idx_q] <= new_st_q;
                    ad_mem[idx_q] <= new_ad_q;
`ifdef LSNN_REFRACTORY_EN
                    rf_mem[idx_q] <= new_rf_q;
`endif
                end
                spike_valid_q <= 1'b1;
                spike_q       <= new_spike_q;
                spike_idx_q   <= idx_q;
                thr_out_q     <= thr_q;
            end
        end
    end

    assign spike_valid   = spike_valid_q;
    assign spike         = spike_q;
    assign spike_idx     = spike_idx_q;
    assign threshold_out = thr_out_q;

endmodule

// File: doc/lsnn_scheduler.md
LSNN_SCHEDULER -- requirements
Module: lsnn_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4, number of virtual adaptive neurons sharing one update datapath.
REQ-002 Parameter ALPHA, default 8, reset value of each neuron's adaptation register.
REQ-003 Parameter B0, default 8, baseline threshold offset.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-high (asserted = 1 resets).
REQ-006 in_valid  input  1  input current request valid.
REQ-007 in_ready  output  1  scheduler can accept a request this cycle.
REQ-008 in_idx  input  clog2(N_NEURONS)  target neuron index.
REQ-009 in_current  input  8  unsigned input current.
REQ-010 spike_valid  output  1  one-cycle pulse, result of one neuron update.
REQ-011 spike_idx  output  clog2(N_NEURONS)  neuron index of the result.
REQ-012 spike  output  1  1 = neuron fired on this update.
REQ-013 threshold_out  output  8  threshold used for the reported update.
REQ-014 busy  output  1  high while an update is in flight (any state other than IDLE).

Function
REQ-015 Per-neuron storage: state[7:0] and adaptation[7:0] for each of N_NEURONS.
REQ-016 FSM states IDLE, LOAD, UPDATE, WRITE; transitions IDLE->LOAD on accept, LOAD->UPDATE, UPDATE->WRITE, WRITE->IDLE, each unconditional after one cycle.
REQ-017 in_ready = 1 only in IDLE; accept = in_valid && in_ready; in_idx and in_current captured on accept.
REQ-018 in_valid while not in IDLE is not accepted; the requester holds it until in_ready.
REQ-019 LOAD: latch the stored state and adaptation of the captured index; threshold = B0 + adaptation, saturating at 255.
REQ-020 UPDATE: new_state = in_current + (state >> 1), 9-bit sum saturated to 255.
REQ-021 UPDATE: spike = (new_state >= threshold).
REQ-022 UPDATE adaptation: if spike, a + (a >> 2), saturated to 255; else (a >> 1) + (a >> 2).
REQ-023 WRITE: store new_state and new adaptation; spike_valid = 1 for exactly this cycle with spike_idx, spike, threshold_out.
REQ-024 Latency: accept at rising edge T gives spike_valid high in the cycle after edge T+3; throughput is one update per 4 cycles.
REQ-025 spike, spike_idx and threshold_out hold their last values while spike_valid = 0.
REQ-026 in_idx >= N_NEURONS is accepted; no storage changes; spike_valid pulses with spike = 0 and threshold_out = 0.

Reset
REQ-027 While rst_n = 1 at a clock edge: FSM -> IDLE; every state = 0; every adaptation = ALPHA; spike_valid, spike, spike_idx, threshold_out = 0; busy = 0.
REQ-028 With rst_n held high, in_ready = 0; in_ready = 1 in the first cycle after rst_n falls.
REQ-029 Reset during LOAD/UPDATE/WRITE abandons the transaction: no write-back, no spike_valid pulse.

Configuration
REQ-030 Macro LSNN_REFRACTORY_EN defined: each neuron has a 2-bit refractory counter, reset value 0.
REQ-031 With the macro: a spike loads the counter with 2 and stores state = 0.
REQ-032 With the macro: an update on a neuron with a nonzero counter decrements the counter, stores state = 0, and forces spike = 0; adaptation follows the no-spike rule.
REQ-033 Without the macro: no counters exist, and new_state is stored unchanged after a spike.

Verification
REQ-034 After reset, neuron 0, current 20 -> spike_valid at T+3: spike = 1, threshold_out = 16; next threshold = 18 (a = 10).
REQ-035 After reset, neuron 1, current 5 -> spike = 0, threshold_out = 16; stored a = 6; a second current of 0 gives threshold_out = 14.
REQ-036 Neuron 2 with stored state 200, current 255 -> stored state 255 (saturated), spike = 1.
REQ-037 in_valid held high with back-to-back requests -> accepts spaced exactly 4 cycles apart; in_ready = 0 while busy = 1.
REQ-038 rst_n pulsed during UPDATE -> no spike_valid; neuron storage reads back as reset values.
REQ-039 LSNN_REFRACTORY_EN, neuron 0: currents 20, 200, 200, 20 -> spikes 1, 0, 0, 1; without the macro -> 1, 1, 1, 1.
